pcileech_ft601_dev: RTL and testbench
=====================================

Name: pcileech_ft601_dev

Overview:
- Synthesizable model of the FT601 chip side of the 245 synchronous-FIFO bus. It is the peer of the FPGA-side FT601 controller.
- Used in loopback and simulation builds to stand in for the USB chip. A host-side stream (testbench or loopback logic) feeds words toward the FPGA and collects words the FPGA writes.
- Includes flow-control injection (forced TXE_N, forced RXF_N gaps) to exercise the controller's retransmit path.

Parameters:
- RX_DEPTH_LOG2, 4, log2 depth of chip-to-FPGA FIFO (words).
- TX_DEPTH_LOG2, 4, log2 depth of FPGA-to-chip FIFO (words).
- TX_RESERVE, 2, TXE_N asserts only while TX FIFO free entries > TX_RESERVE.

Ports:
- clk  in  1  bus clock (FT601 bus clock, shared with controller)
- rst  in  1  synchronous active-high reset
- ft_data_i  in  32  bus data as driven by controller
- ft_data_o  out  32  bus data driven by this block
- ft_data_oe  out  1  enable for ft_data_o onto shared bus
- ft_be_i  in  4  byte enables from controller
- ft_rxf_n  out  1  chip has data for FPGA (active low)
- ft_txe_n  out  1  chip can accept data (active low)
- ft_wr_n  in  1  controller write strobe
- ft_rd_n  in  1  controller read strobe
- ft_oe_n  in  1  controller requests chip to drive bus
- ft_siwu_n  in  1  ignored; sampled for assertion only
- h2d_din  in  32  host word toward FPGA
- h2d_wr_en  in  1  push h2d_din
- h2d_full  out  1  RX FIFO full
- d2h_dout  out  32  word received from FPGA
- d2h_valid  out  1  d2h_dout valid, one-cycle pulse per word
- inj_txe_hold  in  1  force ft_txe_n high (registered)
- inj_rxf_hold  in  1  force ft_rxf_n high (registered)
- stat_tx_drop  out  16  count of WR_N-low cycles with TXE_N high (wraps)

Behaviour:
- Reset values: ft_rxf_n=1, ft_txe_n=1, ft_data_oe=0, ft_data_o=0, d2h_valid=0, d2h_dout=0, h2d_full=0, stat_tx_drop=0. Both FIFOs are emptied and the state goes to IDLE. Reset mid-burst drops all buffered words.
- Byte order: bus lane [31:24] carries word byte [7:0]. Apply byte swap both directions so that h2d_din reaches the controller's dout unchanged, and the controller's din reaches d2h_dout unchanged.
- Bus FSM states: IDLE, RX_OE, RX_BURST, TX_BURST.
  - IDLE -> RX_OE when ft_oe_n sampled low.
  - IDLE -> TX_BURST when ft_wr_n sampled low.
  - RX_OE -> RX_BURST after one cycle. This is the bus turnaround: ft_data_oe goes to 1 in RX_BURST only.
  - RX_BURST -> IDLE when ft_oe_n sampled high; ft_data_oe drops the same edge.
  - TX_BURST -> IDLE when ft_wr_n sampled high.
  - ft_wr_n low while ft_oe_n low is a protocol error: flag in simulation, word ignored.
- ft_rxf_n (registered) = RX FIFO empty | inj_rxf_hold | state==TX_BURST.
- ft_txe_n (registered) = (TX free <= TX_RESERVE) | inj_txe_hold | state in {RX_OE, RX_BURST}.
- RX path:
  - ft_data_o always shows the swapped RX FIFO head.
  - Pop at an edge where state==RX_BURST & ~ft_rd_n & ~ft_rxf_n.
  - The next head is valid in the following cycle. When the FIFO empties, ft_rxf_n rises in the same cycle the last word leaves the head.
  - h2d_wr_en while h2d_full: word discarded, simulation error.
  - Simultaneous push and pop is supported at any occupancy.
- TX path:
  - A word is accepted at an edge where ~ft_wr_n & ~ft_txe_n & ft_be_i==4'hF; it is pushed to the TX FIFO.
  - ~ft_wr_n & ft_txe_n: word dropped, stat_tx_drop+1. The controller must retransmit.
  - ft_be_i!=4'hF with WR_N low: word dropped, simulation error.
- d2h: TX FIFO drains one word per cycle when non-empty. d2h_dout/d2h_valid are registered, so latency is 2 cycles from bus acceptance to d2h_valid.
- inj_* take effect on ft_*_n one cycle after assertion.

Decomposition:
- Package pcileech_ft601_pkg holds:
  - typedef ft601_word_t (32 bit)
  - byteswap32 function
  - bus FSM state enum
  - constant FT601_BE_ALL=4'hF
- One sub-module pcileech_ft601_dev_fifo: synchronous FIFO with params DEPTH_LOG2 and data width, outputs count/empty/full, first-word-fall-through. Instantiated twice (RX, TX).

Test Plan:
- Push h2d 0x11223344, 0xAABBCCDD with the controller idle -> ft_rxf_n falls; the controller reads; ft_data_o shows 0x44332211 then 0xDDCCBBAA; ft_rxf_n rises after the second pop; controller dout sequence matches the h2d words.
- Controller writes 8 words 0x1..0x8, TXE free -> d2h_valid pulses 8 times with 0x1..0x8 in order; stat_tx_drop=0.
- inj_txe_hold pulsed 3 cycles mid 8-word write -> stat_tx_drop>0; after controller retransmit, d2h sequence is exactly 0x1..0x8 with no duplicates or gaps.
- Fill RX FIFO to 16 words; 17th h2d_wr_en -> h2d_full=1, word discarded; readback yields the first 16 only.
- RX FIFO non-empty and TX pending simultaneously -> controller reads first (ft_txe_n high during RX_OE/RX_BURST); TX burst follows; ft_data_oe never 1 while ft_wr_n low.
- rst asserted in RX_BURST with 5 words queued -> next cycle ft_data_oe=0, ft_rxf_n=1, h2d_full=0; subsequent push/read works from empty.

Source files
------------

// File: rtl/pcileech_ft601_pkg.sv
// Shared types and helpers for the FT601 chip-side bus model.
// Bus lane [31:24] carries word byte [7:0], so words cross the bus byte-swapped.
package pcileech_ft601_pkg;

  typedef logic [31:0] ft601_word_t;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_RX_OE    = 2'd1,
    ST_RX_BURST = 2'd2,
    ST_TX_BURST = 2'd3
  } ft601_state_t;

  localparam logic [3:0] FT601_BE_ALL = 4'hF;

  function automatic ft601_word_t byteswap32(input ft601_word_t w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

endpackage

// File: rtl/pcileech_ft601_dev_chk.sv
// Bus protocol checks on the controller side of the FT601 interface.
module pcileech_ft601_dev_chk
  import pcileech_ft601_pkg::*;
(
  input logic       clk,
  input logic       rst,
  input logic       ft_wr_n,
  input logic       ft_oe_n,
  input logic [3:0] ft_be_i,
  input logic       ft_siwu_n
);

  a_no_wr_during_oe: assert property (@(posedge clk) disable iff (rst) !(!ft_wr_n && !ft_oe_n));
  a_full_be_on_wr:   assert property (@(posedge clk) disable iff (rst) ft_wr_n || (ft_be_i == FT601_BE_ALL));
  a_siwu_known:      assert property (@(posedge clk) disable iff (rst) !$isunknown(ft_siwu_n));

endmodule

// File: rtl/pcileech_ft601_dev_fifo.sv
// First-word-fall-through synchronous FIFO; dout shows the head while not empty.
// Writes while full and reads while empty are ignored.
module pcileech_ft601_dev_fifo #(
  parameter int DEPTH_LOG2 = 4,
  parameter int WIDTH      = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [WIDTH-1:0]      din,
  input  logic                  rd_en,
  output logic [WIDTH-1:0]      dout,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  empty,
  output logic                  full
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  logic [WIDTH-1:0]      mem_r [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_r;
  logic [DEPTH_LOG2-1:0] rd_ptr_r;
  logic [DEPTH_LOG2:0]   count_r;
  logic                  push_s;
  logic                  pop_s;

  assign empty  = (count_r == {(DEPTH_LOG2+1){1'b0}});
  assign full   = count_r[DEPTH_LOG2];
  assign count  = count_r;
  assign dout   = mem_r[rd_ptr_r];
  assign push_s = wr_en & ~full;
  assign pop_s  = rd_en & ~empty;

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r <= {DEPTH_LOG2{1'b0}};
      rd_ptr_r <= {DEPTH_LOG2{1'b0}};
      count_r  <= {(DEPTH_LOG2+1){1'b0}};
    end else begin
      if (push_s) wr_ptr_r <= wr_ptr_r + DEPTH_LOG2'(1);
      if (pop_s)  rd_ptr_r <= rd_ptr_r + DEPTH_LOG2'(1);
      count_r <= count_r + (DEPTH_LOG2+1)'(push_s) - (DEPTH_LOG2+1)'(pop_s);
    end
  end

  // Storage array, deliberately not reset.
  always_ff @(posedge clk) begin
    if (push_s) mem_r[wr_ptr_r] <= din;
  end

endmodule

// File: rtl/pcileech_ft601_dev.sv
// FT601 chip-side model of the 245 synchronous-FIFO bus: RX FIFO toward the FPGA,
// TX FIFO from the FPGA, bus FSM with turnaround, and flow-control injection.
module pcileech_ft601_dev
  import pcileech_ft601_pkg::*;
#(
  parameter int RX_DEPTH_LOG2 = 4,
  parameter int TX_DEPTH_LOG2 = 4,
  parameter int TX_RESERVE    = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] ft_data_i,
  output logic [31:0] ft_data_o,
  output logic        ft_data_oe,
  input  logic [3:0]  ft_be_i,
  output logic        ft_rxf_n,
  output logic        ft_txe_n,
  input  logic        ft_wr_n,
  input  logic        ft_rd_n,
  input  logic        ft_oe_n,
  input  logic        ft_siwu_n,
  input  logic [31:0] h2d_din,
  input  logic        h2d_wr_en,
  output logic        h2d_full,
  output logic [31:0] d2h_dout,
  output logic        d2h_valid,
  input  logic        inj_txe_hold,
  input  logic        inj_rxf_hold,
  output logic [15:0] stat_tx_drop
);

  localparam logic [TX_DEPTH_LOG2:0] TX_DEPTH_W = (TX_DEPTH_LOG2+1)'(1 << TX_DEPTH_LOG2);
  localparam logic [TX_DEPTH_LOG2:0] TX_RES_W   = (TX_DEPTH_LOG2+1)'(TX_RESERVE);

  ft601_state_t             state_r;
  ft601_state_t             state_nxt_s;
  logic                     ft_rxf_r, ft_txe_r, ft_data_oe_r, d2h_valid_r;
  ft601_word_t              d2h_dout_r;
  logic [15:0]              stat_tx_drop_r;

  ft601_word_t              rx_head_s, tx_head_s;
  logic [RX_DEPTH_LOG2:0]   rx_count_s, rx_cnt_nxt_s;
  logic [TX_DEPTH_LOG2:0]   tx_count_s, tx_cnt_nxt_s, tx_free_nxt_s;
  logic                     rx_empty_s, rx_full_s, tx_empty_s, tx_full_s;
  logic                     rx_push_s, rx_pop_s, tx_push_s, tx_pop_s, tx_drop_s;

  assign rx_push_s = h2d_wr_en & ~rx_full_s;
  assign rx_pop_s  = (state_r == ST_RX_BURST) & ~ft_rd_n & ~ft_rxf_r & ~rx_empty_s;
  // A write during an active read is a protocol violation and is never accepted.
  assign tx_push_s = ~ft_wr_n & ~ft_txe_r & ft_oe_n & (ft_be_i == FT601_BE_ALL) & ~tx_full_s;
  assign tx_drop_s = ~ft_wr_n & ft_txe_r;
  assign tx_pop_s  = ~tx_empty_s;

  assign rx_cnt_nxt_s  = rx_count_s + (RX_DEPTH_LOG2+1)'(rx_push_s) - (RX_DEPTH_LOG2+1)'(rx_pop_s);
  assign tx_cnt_nxt_s  = tx_count_s + (TX_DEPTH_LOG2+1)'(tx_push_s) - (TX_DEPTH_LOG2+1)'(tx_pop_s);
  assign tx_free_nxt_s = TX_DEPTH_W - tx_cnt_nxt_s;

  pcileech_ft601_dev_fifo #(.DEPTH_LOG2(RX_DEPTH_LOG2), .WIDTH(32)) u_rx_fifo (
    .clk(clk), .rst(rst), .wr_en(rx_push_s), .din(h2d_din), .rd_en(rx_pop_s),
    .dout(rx_head_s), .count(rx_count_s), .empty(rx_empty_s), .full(rx_full_s)
  );

  pcileech_ft601_dev_fifo #(.DEPTH_LOG2(TX_DEPTH_LOG2), .WIDTH(32)) u_tx_fifo (
    .clk(clk), .rst(rst), .wr_en(tx_push_s), .din(byteswap32(ft_data_i)), .rd_en(tx_pop_s),
    .dout(tx_head_s), .count(tx_count_s), .empty(tx_empty_s), .full(tx_full_s)
  );

  pcileech_ft601_dev_chk u_chk (
    .clk(clk), .rst(rst), .ft_wr_n(ft_wr_n), .ft_oe_n(ft_oe_n),
    .ft_be_i(ft_be_i), .ft_siwu_n(ft_siwu_n)
  );

  // Bus FSM next-state decode.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (!ft_oe_n)      state_nxt_s = ST_RX_OE;
        else if (!ft_wr_n) state_nxt_s = ST_TX_BURST;
        else               state_nxt_s = ST_IDLE;
      end
      ST_RX_OE:    state_nxt_s = ST_RX_BURST;
      ST_RX_BURST: begin
        if (ft_oe_n) state_nxt_s = ST_IDLE;
        else         state_nxt_s = ST_RX_BURST;
      end
      ST_TX_BURST: begin
        if (ft_wr_n) state_nxt_s = ST_IDLE;
        else         state_nxt_s = ST_TX_BURST;
      end
      default:     state_nxt_s = ST_IDLE;
    endcase
  end

  // Flags are computed from next-cycle occupancy so RXF_N rises as the last word leaves.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r        <= ST_IDLE;
      ft_rxf_r       <= 1'b1;
      ft_txe_r       <= 1'b1;
      ft_data_oe_r   <= 1'b0;
      d2h_valid_r    <= 1'b0;
      d2h_dout_r     <= 32'h0000_0000;
      stat_tx_drop_r <= 16'h0000;
    end else begin
      state_r        <= state_nxt_s;
      ft_data_oe_r   <= (state_nxt_s == ST_RX_BURST);
      ft_rxf_r       <= (rx_cnt_nxt_s == {(RX_DEPTH_LOG2+1){1'b0}}) | inj_rxf_hold |
                        (state_nxt_s == ST_TX_BURST);
      ft_txe_r       <= (tx_free_nxt_s <= TX_RES_W) | inj_txe_hold |
                        (state_nxt_s == ST_RX_OE) | (state_nxt_s == ST_RX_BURST);
      d2h_valid_r    <= tx_pop_s;
      d2h_dout_r     <= tx_pop_s ? tx_head_s : d2h_dout_r;
      stat_tx_drop_r <= stat_tx_drop_r + {15'd0, tx_drop_s};
    end
  end

  assign ft_data_o    = rx_empty_s ? 32'h0000_0000 : byteswap32(rx_head_s);
  assign ft_data_oe   = ft_data_oe_r;
  assign ft_rxf_n     = ft_rxf_r;
  assign ft_txe_n     = ft_txe_r;
  assign h2d_full     = rx_full_s;
  assign d2h_dout     = d2h_dout_r;
  assign d2h_valid    = d2h_valid_r;
  assign stat_tx_drop = stat_tx_drop_r;

endmodule

// File: tb/tb_pcileech_ft601_dev.sv
// Directed and randomized bench for the FT601 chip-side model, acting as the FPGA controller.
module tb_pcileech_ft601_dev;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] ft_data_i, ft_data_o, h2d_din, d2h_dout;
  logic [3:0]  ft_be_i;
  logic        ft_data_oe, ft_rxf_n, ft_txe_n, ft_wr_n, ft_rd_n, ft_oe_n, ft_siwu_n;
  logic        h2d_wr_en, h2d_full, d2h_valid, inj_txe_hold, inj_rxf_hold;
  logic [15:0] stat_tx_drop;

  int          n_cmp = 0;
  int          n_err = 0;
  int          oe_wr_clash = 0;
  int          exp_drop = 0;
  logic [31:0] rx_ref[$];
  logic [31:0] tx_src[$];
  logic [31:0] d2h_q[$];

  always #5 clk = ~clk;

  pcileech_ft601_dev dut (
    .clk(clk), .rst(rst), .ft_data_i(ft_data_i), .ft_data_o(ft_data_o), .ft_data_oe(ft_data_oe),
    .ft_be_i(ft_be_i), .ft_rxf_n(ft_rxf_n), .ft_txe_n(ft_txe_n), .ft_wr_n(ft_wr_n),
    .ft_rd_n(ft_rd_n), .ft_oe_n(ft_oe_n), .ft_siwu_n(ft_siwu_n), .h2d_din(h2d_din),
    .h2d_wr_en(h2d_wr_en), .h2d_full(h2d_full), .d2h_dout(d2h_dout), .d2h_valid(d2h_valid),
    .inj_txe_hold(inj_txe_hold), .inj_rxf_hold(inj_rxf_hold), .stat_tx_drop(stat_tx_drop)
  );

  // Host-side collector and bus-contention watch, sampled mid-cycle.
  always @(negedge clk) begin
    if (!rst && d2h_valid) d2h_q.push_back(d2h_dout);
    if (ft_data_oe && !ft_wr_n) oe_wr_clash++;
  end

  function automatic logic [31:0] swap(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  // Host pushes one word; the reference FIFO keeps at most 16 words.
  task automatic host_push(input logic [31:0] w);
    h2d_din   = w;
    h2d_wr_en = 1'b1;
    tick;
    h2d_wr_en = 1'b0;
    if (rx_ref.size() < 16) rx_ref.push_back(w);
  endtask

  // Controller drains everything the chip offers and compares against the reference.
  task automatic ctl_read(input string tag);
    int got;
    int exp_n;
    got   = 0;
    exp_n = rx_ref.size();
    ft_oe_n = 1'b0;
    tick;
    chk({tag, "_txe_in_rx_oe"}, 32'(ft_txe_n), 32'd1);
    chk({tag, "_oe_turnaround"}, 32'(ft_data_oe), 32'd0);
    tick;
    chk({tag, "_oe_in_burst"}, 32'(ft_data_oe), 32'd1);
    ft_rd_n = 1'b0;
    for (int c = 0; c < 40; c++) begin
      if (ft_rxf_n) break;
      got++;
      if (got <= exp_n) chk({tag, "_dout"}, swap(ft_data_o), rx_ref.pop_front());
      tick;
    end
    chk({tag, "_word_count"}, 32'(got), 32'(exp_n));
    ft_rd_n = 1'b1;
    ft_oe_n = 1'b1;
    tick;
    chk({tag, "_oe_release"}, 32'(ft_data_oe), 32'd0);
  endtask

  // Controller writes tx_src, retransmitting any word presented while TXE_N was high.
  task automatic ctl_write(input int inj_at, input int inj_drops);
    int  i;
    int  inj_left;
    bit  fired;
    bit  acc;
    i = 0; inj_left = 0; fired = 1'b0;
    d2h_q.delete();
    ft_wr_n = 1'b0;
    ft_be_i = 4'hF;
    for (int c = 0; c < 200 && i < tx_src.size(); c++) begin
      if (i == inj_at && !fired) begin
        inj_left = 3;
        fired    = 1'b1;
      end
      ft_data_i    = swap(tx_src[i]);
      inj_txe_hold = (inj_left > 0);
      acc          = (ft_txe_n == 1'b0);
      tick;
      if (acc) i++;
      if (inj_left > 0) inj_left--;
    end
    ft_wr_n      = 1'b1;
    inj_txe_hold = 1'b0;
    tick;
    for (int c = 0; c < 20 && d2h_q.size() < tx_src.size(); c++) tick;
    tick; tick; tick;
    exp_drop += inj_drops;
    chk("d2h_count", 32'(d2h_q.size()), 32'(tx_src.size()));
    for (int k = 0; k < tx_src.size() && k < d2h_q.size(); k++) chk("d2h_word", d2h_q[k], tx_src[k]);
    chk("stat_tx_drop", 32'(stat_tx_drop), 32'(exp_drop));
  endtask

  initial begin
    rst = 1'b1; ft_data_i = 32'h0; ft_be_i = 4'hF; ft_wr_n = 1'b1; ft_rd_n = 1'b1;
    ft_oe_n = 1'b1; ft_siwu_n = 1'b1; h2d_din = 32'h0; h2d_wr_en = 1'b0;
    inj_txe_hold = 1'b0; inj_rxf_hold = 1'b0;
    tick; tick;
    chk("rst_rxf_n", 32'(ft_rxf_n), 32'd1);
    chk("rst_txe_n", 32'(ft_txe_n), 32'd1);
    chk("rst_data_oe", 32'(ft_data_oe), 32'd0);
    chk("rst_data_o", ft_data_o, 32'h0);
    chk("rst_d2h_valid", 32'(d2h_valid), 32'd0);
    chk("rst_d2h_dout", d2h_dout, 32'h0);
    chk("rst_h2d_full", 32'(h2d_full), 32'd0);
    chk("rst_stat", 32'(stat_tx_drop), 32'd0);
    rst = 1'b0;
    tick;
    chk("idle_txe_n", 32'(ft_txe_n), 32'd0);

    // Two host words reach the controller byte-swapped on the bus, unchanged at dout.
    host_push(32'h11223344);
    host_push(32'hAABBCCDD);
    chk("t1_rxf_low", 32'(ft_rxf_n), 32'd0);
    chk("t1_bus_head", ft_data_o, 32'h44332211);
    ctl_read("t1");
    chk("t1_rxf_high", 32'(ft_rxf_n), 32'd1);

    // RXF_N hold injection.
    host_push(32'h0000_0005);
    inj_rxf_hold = 1'b1;
    tick;
    chk("inj_rxf_high", 32'(ft_rxf_n), 32'd1);
    inj_rxf_hold = 1'b0;
    tick;
    chk("inj_rxf_release", 32'(ft_rxf_n), 32'd0);
    ctl_read("inj_rxf");

    // Clean 8-word write, then the same with a 3-cycle TXE_N hold in the middle.
    tx_src.delete();
    for (int k = 1; k <= 8; k++) tx_src.push_back(32'(k));
    ctl_write(-1, 0);
    ctl_write(3, 3);

    // Overflow: the 17th word is discarded.
    for (int k = 0; k < 17; k++) begin
      host_push($urandom);
      if (k == 15) chk("t4_full_at_16", 32'(h2d_full), 32'd1);
    end
    chk("t4_full_after_17", 32'(h2d_full), 32'd1);
    ctl_read("t4");
    chk("t4_full_cleared", 32'(h2d_full), 32'd0);

    // Read and write both pending: read served first, TX follows.
    host_push($urandom);
    host_push($urandom);
    tx_src.delete();
    for (int k = 0; k < 3; k++) tx_src.push_back($urandom);
    chk("t5_rxf_low", 32'(ft_rxf_n), 32'd0);
    chk("t5_txe_low", 32'(ft_txe_n), 32'd0);
    ctl_read("t5");
    ctl_write(-1, 0);

    // Randomized rounds.
    for (int r = 0; r < 4; r++) begin
      int n_rx;
      int n_tx;
      n_rx = $urandom_range(1, 6);
      for (int k = 0; k < n_rx; k++) host_push($urandom);
      ctl_read("rnd_rx");
      n_tx = $urandom_range(2, 6);
      tx_src.delete();
      for (int k = 0; k < n_tx; k++) tx_src.push_back($urandom);
      if ($urandom_range(0, 1) == 1) ctl_write($urandom_range(0, n_tx - 2), 3);
      else                           ctl_write(-1, 0);
    end
    chk("no_oe_during_wr", 32'(oe_wr_clash), 32'd0);

    // Reset in the middle of a read burst with 5 words queued.
    for (int k = 0; k < 5; k++) host_push($urandom);
    ft_oe_n = 1'b0;
    tick; tick;
    chk("t6_in_burst", 32'(ft_data_oe), 32'd1);
    rst = 1'b1;
    tick;
    chk("t6_oe_dropped", 32'(ft_data_oe), 32'd0);
    chk("t6_rxf_high", 32'(ft_rxf_n), 32'd1);
    chk("t6_full_low", 32'(h2d_full), 32'd0);
    rst = 1'b0;
    ft_oe_n = 1'b1;
    rx_ref.delete();
    exp_drop = 0;
    tick;
    chk("t6_stat_cleared", 32'(stat_tx_drop), 32'd0);
    host_push(32'hCAFEF00D);
    ctl_read("t6");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
